// File: rtl/motor_soft_start.sv
// Motor soft-start: maps a 2-bit speed level to a target duty, slews the applied
// duty toward it at a fixed rate, and drives a period-aligned PWM with an
// immediate emergency-stop override.
module motor_soft_start #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned RAMP_TICKS = 50000,
    parameter int unsigned STEP       = 5,
    parameter int unsigned DUTY_L1    = 85,
    parameter int unsigned DUTY_L2    = 170,
    parameter int unsigned DUTY_L3    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] target_level,
    input  logic       target_valid,
    input  logic       estop,
    output logic       pwm_out,
    output logic [7:0] duty_now,
    output logic       at_target,
    output logic       ramping,
    output logic [2:0] state
);

    localparam int unsigned DW = 8;
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_TICKS - 1);
    localparam logic [8:0]    STEP9      = 9'(STEP);
    localparam logic [DW-1:0] PWM_LAST   = DW'(255);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_HOLD      = 3'd3,
        ST_STOPPED   = 3'd4
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   target_q;
    logic [DW-1:0]   duty_q;
    logic [DW-1:0]   duty_active_q;
    logic [PW-1:0]   presc_q;
    logic [DW-1:0]   pwm_cnt_q;
    logic [RW-1:0]   ramp_cnt_q;
    logic            pwm_out_q;

    logic [DW-1:0]   lvl_duty;
    logic [DW-1:0]   eff_tgt;
    logic [DW-1:0]   duty_step;
    logic [8:0]      tgt9;
    logic [8:0]      duty9;
    logic [8:0]      gap9;
    logic [8:0]      inc9;
    logic [8:0]      step9;

    logic            tick;
    logic [PW-1:0]   presc_d;
    logic [DW-1:0]   pwm_cnt_d;
    logic [DW-1:0]   duty_active_d;

    // Level map and the target in force this cycle (a strobe takes effect immediately for decisions)
    always_comb begin
        lvl_duty = '0;
        case (target_level)
            2'd1:    lvl_duty = DW'(DUTY_L1);
            2'd2:    lvl_duty = DW'(DUTY_L2);
            2'd3:    lvl_duty = DW'(DUTY_L3);
            default: lvl_duty = '0;
        endcase
        eff_tgt = target_valid ? lvl_duty : target_q;
    end

    // One ramp step toward the target, clamped to the remaining gap so it never overshoots
    always_comb begin
        tgt9      = {1'b0, eff_tgt};
        duty9     = {1'b0, duty_q};
        gap9      = (tgt9 > duty9) ? (tgt9 - duty9) : (duty9 - tgt9);
        inc9      = (gap9 < STEP9) ? gap9 : STEP9;
        step9     = (tgt9 > duty9) ? (duty9 + inc9) : (duty9 - inc9);
        duty_step = step9[DW-1:0];
    end

    // Prescaler tick and period-boundary reload of the applied duty
    always_comb begin
        tick          = (presc_q == PRESC_LAST);
        presc_d       = tick ? '0 : (presc_q + PW'(1));
        pwm_cnt_d     = tick ? (pwm_cnt_q + DW'(1)) : pwm_cnt_q;
        duty_active_d = (tick && (pwm_cnt_q == PWM_LAST)) ? duty_q : duty_active_q;
    end

    // Control FSM: target register, ramp counter and ramped duty
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            duty_q     <= '0;
            ramp_cnt_q <= '0;
        end else if (estop) begin
            state_q    <= ST_STOPPED;
            target_q   <= '0;
            duty_q     <= '0;
            ramp_cnt_q <= '0;
        end else begin
            target_q <= eff_tgt;
            case (state_q)
                ST_STOPPED: begin
                    state_q <= ST_IDLE;
                end
                ST_IDLE, ST_HOLD: begin
                    if (eff_tgt > duty_q) begin
                        state_q    <= ST_RAMP_UP;
                        ramp_cnt_q <= '0;
                    end else if (eff_tgt < duty_q) begin
                        state_q    <= ST_RAMP_DOWN;
                        ramp_cnt_q <= '0;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (duty_q == eff_tgt) begin
                        state_q <= (eff_tgt == '0) ? ST_IDLE : ST_HOLD;
                    end else if ((eff_tgt > duty_q) && (state_q == ST_RAMP_DOWN)) begin
                        state_q    <= ST_RAMP_UP;
                        ramp_cnt_q <= '0;
                    end else if ((eff_tgt < duty_q) && (state_q == ST_RAMP_UP)) begin
                        state_q    <= ST_RAMP_DOWN;
                        ramp_cnt_q <= '0;
                    end else if (ramp_cnt_q == RAMP_LAST) begin
                        ramp_cnt_q <= '0;
                        duty_q     <= duty_step;
                    end else begin
                        ramp_cnt_q <= ramp_cnt_q + RW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // PWM counter, applied duty and registered comparator output
    always_ff @(posedge clk) begin
        if (reset || estop) begin
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            duty_active_q <= '0;
            pwm_out_q     <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            duty_active_q <= duty_active_d;
            pwm_out_q     <= (pwm_cnt_d < duty_active_d);
        end
    end

    assign pwm_out   = pwm_out_q;
    assign duty_now  = duty_q;
    assign at_target = (duty_q == target_q);
    assign ramping   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign state     = state_q;

endmodule

// File: tb/tb_motor_soft_start.sv
// Bench for motor_soft_start: two instances (step 5 and step 7) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_motor_soft_start;

    localparam int unsigned CLK_DIV    = 1;
    localparam int unsigned RAMP_TICKS = 4;
    localparam int unsigned DUTY_L1    = 20;
    localparam int unsigned DUTY_L2    = 170;
    localparam int unsigned DUTY_L3    = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] lvl;
    logic       tv;
    logic       estop;

    logic       pwm_a, at_a, rmp_a;
    logic [7:0] duty_a;
    logic [2:0] st_a;
    logic       pwm_b, at_b, rmp_b;
    logic [7:0] duty_b;
    logic [2:0] st_b;

    int checks = 0;
    int errors = 0;

    // behavioural model, one slot per instance
    int step_sz[2] = '{5, 7};
    int m_tgt[2];
    int m_duty[2];
    int m_act[2];
    int m_ticks[2];
    int m_since[2];
    int m_state[2];

    motor_soft_start #(
        .CLK_DIV(CLK_DIV), .RAMP_TICKS(RAMP_TICKS), .STEP(5),
        .DUTY_L1(DUTY_L1), .DUTY_L2(DUTY_L2), .DUTY_L3(DUTY_L3)
    ) u_dut_a (
        .clk(clk), .reset(reset), .target_level(lvl), .target_valid(tv), .estop(estop),
        .pwm_out(pwm_a), .duty_now(duty_a), .at_target(at_a), .ramping(rmp_a), .state(st_a)
    );

    motor_soft_start #(
        .CLK_DIV(CLK_DIV), .RAMP_TICKS(RAMP_TICKS), .STEP(7),
        .DUTY_L1(DUTY_L1), .DUTY_L2(DUTY_L2), .DUTY_L3(DUTY_L3)
    ) u_dut_b (
        .clk(clk), .reset(reset), .target_level(lvl), .target_valid(tv), .estop(estop),
        .pwm_out(pwm_b), .duty_now(duty_b), .at_target(at_b), .ramping(rmp_b), .state(st_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lvl_map(input logic [1:0] l);
        case (l)
            2'd1:    return DUTY_L1;
            2'd2:    return DUTY_L2;
            2'd3:    return DUTY_L3;
            default: return 0;
        endcase
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Advance model k by one clock edge using the inputs that were stable before it
    task automatic model_edge(input int k);
        int eff;
        int ns;
        int nd;
        if (reset) begin
            m_tgt[k] = 0; m_duty[k] = 0; m_act[k] = 0;
            m_ticks[k] = 0; m_since[k] = 0; m_state[k] = 0;
        end else if (estop) begin
            m_tgt[k] = 0; m_duty[k] = 0; m_act[k] = 0;
            m_ticks[k] = 0; m_since[k] = 0; m_state[k] = 4;
        end else begin
            eff = tv ? lvl_map(lvl) : m_tgt[k];
            if (m_state[k] == 4)       ns = 0;
            else if (m_duty[k] == eff) ns = (eff == 0) ? 0 : 3;
            else                       ns = (eff > m_duty[k]) ? 1 : 2;
            nd = m_duty[k];
            if (ns == 1 || ns == 2) begin
                if (ns == m_state[k]) begin
                    m_since[k]++;
                    if (m_since[k] % RAMP_TICKS == 0) begin
                        if (eff > nd) nd = nd + min2(step_sz[k], eff - nd);
                        else          nd = nd - min2(step_sz[k], nd - eff);
                    end
                end else begin
                    m_since[k] = 0;
                end
            end
            m_ticks[k]++;
            if (m_ticks[k] % (CLK_DIV * 256) == 0) m_act[k] = m_duty[k];
            m_duty[k]  = nd;
            m_tgt[k]   = eff;
            m_state[k] = ns;
        end
    endtask

    function automatic logic exp_pwm(input int k);
        return (((m_ticks[k] / CLK_DIV) % 256) < m_act[k]);
    endfunction

    // One clock: update models at the edge, compare 1 time unit later, drop the strobe
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("a_duty",   32'(duty_a), 32'(m_duty[0]));
        check("a_state",  32'(st_a),   32'(m_state[0]));
        check("a_pwm",    32'(pwm_a),  32'(exp_pwm(0)));
        check("a_attgt",  32'(at_a),   32'(m_duty[0] == m_tgt[0]));
        check("a_ramp",   32'(rmp_a),  32'(m_state[0] == 1 || m_state[0] == 2));
        check("b_duty",   32'(duty_b), 32'(m_duty[1]));
        check("b_state",  32'(st_b),   32'(m_state[1]));
        check("b_pwm",    32'(pwm_b),  32'(exp_pwm(1)));
        check("b_attgt",  32'(at_b),   32'(m_duty[1] == m_tgt[1]));
        check("b_ramp",   32'(rmp_b),  32'(m_state[1] == 1 || m_state[1] == 2));
        tv = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [1:0] l);
        lvl = l;
        tv  = 1'b1;
    endtask

    initial begin
        reset = 1'b1; tv = 1'b0; lvl = 2'd0; estop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_tgt[k] = 0; m_duty[k] = 0; m_act[k] = 0;
            m_ticks[k] = 0; m_since[k] = 0; m_state[k] = 0;
        end
        run(3);
        reset = 1'b0;
        run(2);

        // ramp to level 1, hold across several PWM periods
        strobe(2'd1); run(700);
        // ramp down to stop
        strobe(2'd0); run(300);
        // reverse mid-ramp: head for 170, retarget level 1 at duty 60
        strobe(2'd2); run(49);
        strobe(2'd1); run(250);
        // up to 255, then back down to 170
        strobe(2'd3); run(300);
        strobe(2'd3); run(20);
        strobe(2'd2); run(300);
        // estop together with a strobe, mid-period
        run(37);
        estop = 1'b1; strobe(2'd3); run(10);
        estop = 1'b0; run(60);
        strobe(2'd2); run(150);
        // reset mid-ramp
        reset = 1'b1; run(1);
        reset = 1'b0; run(20);

        // randomized traffic
        for (int i = 0; i < 16000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 7) strobe(2'($urandom_range(0, 3)));
            if (!estop && r == 500)                        estop = 1'b1;
            else if (estop && $urandom_range(0, 7) == 0)   estop = 1'b0;
            reset = (r == 999 && $urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b0; estop = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
